pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
Generates a programmable burst of high pulses on a single output, timed from the system clock. It is the stimulus-side counterpart of the high-pulse counting block. Typical use in PLL testbenches: drive a known number of edges with known high/low widths into a DUT or counter, then compare the counts. A start/busy/done handshake lets a test sequencer launch bursts back to back.

Parameters:
CNT_W, 32, width of the pulse-count request and the sent-pulse counter
DUR_W, 16, width of the high/low duration fields, in clk cycles

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  one-cycle request to launch a burst; sampled only in IDLE
abort  input  1  cancels a running burst
pulse_count  input  CNT_W  number of pulses in the burst; latched on accepted start
high_cycles  input  DUR_W  high width in clk cycles; latched on accepted start
low_cycles  input  DUR_W  low width in clk cycles; latched on accepted start
pulse_out  output  1  generated pulse train (registered)
busy  output  1  high from the cycle after an accepted start until the burst ends
done  output  1  one-cycle strobe when a burst completes normally
sent  output  CNT_W  pulses fully emitted in the current or last burst

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; pulse_out=0, busy=0, done=0, sent=0; latched config cleared.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: IDLE, HIGH, LOW, FIN.
- IDLE:
  - start=1 and pulse_count!=0: latch config, set sent=0, go to HIGH.
  - start=1 and pulse_count==0: go to FIN. No pulse is emitted; sent is set to 0.
  - Next cycle: pulse_out=1 and busy=1 when entering HIGH.
- HIGH: pulse_out=1 for exactly max(high_cycles,1) cycles. On the last HIGH cycle:
  - sent increments by 1.
  - If sent+1 == pulse_count, go to FIN.
  - Otherwise go to LOW.
- LOW: pulse_out=0 for exactly max(low_cycles,1) cycles, then go to HIGH.
- Zero-duration rule: high_cycles=0 and low_cycles=0 are each treated as 1. The fastest legal waveform is therefore clk/2.
- FIN: lasts one cycle. done=1, busy=0, pulse_out=0, then go to IDLE.
  - For a zero-count start, IDLE→FIN gives done one cycle after start, with busy never asserted.
- Duration counter:
  - DUR_W wide; loaded with the target minus 1 on state entry; decrements; the phase ends at 0.
  - Widths above 2^DUR_W-1 are not representable.
- sent:
  - Never wraps inside a burst, since it is bounded by pulse_count.
  - Holds its value in IDLE until the next accepted start.
- start while busy (HIGH/LOW/FIN): ignored. It is not queued.
- abort:
  - In HIGH or LOW: next state is IDLE; pulse_out=0, busy=0, done stays 0; sent keeps the count of completed pulses.
  - A truncated high phase is not counted.
  - In IDLE: no effect.
  - abort and start asserted together in IDLE: abort wins, and the start is dropped.
- Config inputs may change freely while busy. Only the latched copies are used.
- Back to back: start may be accepted in the IDLE cycle right after FIN. The minimum gap between bursts is therefore 2 cycles of pulse_out=0 (FIN, IDLE).
- Reset mid-burst: pulse_out drops to 0 immediately (asynchronous); no done strobe.
- Latency: start accepted at edge N; pulse_out rises at edge N+1.
- Total burst length: pulse_count*H + (pulse_count-1)*L cycles of HIGH/LOW, where H=max(high_cycles,1) and L=max(low_cycles,1). One FIN cycle follows.

Decomposition:
- Shared package: the state enumeration (IDLE, HIGH, LOW, FIN) and the default widths CNT_W/DUR_W, so the counter-side checker can reuse them.
- One natural sub-module: pulse_phase_timer. It is a loadable down-counter with load, value, and an expired flag, used for the HIGH and LOW phases.
- FSM and sent counter stay in the top module.

Test Plan:
- Basic burst: start with count=3, high=2, low=1 → pulse_out pattern 1,1,0,1,1,0,1,1, then done=1 for one cycle. sent=3, busy high for 8 cycles, then 0.
- Zero handling:
  - count=0 → done one cycle after start, pulse_out stays 0, sent=0, busy never 1.
  - high=0, low=0, count=4 → pulse_out toggles every cycle, 4 highs.
- Abort: count=10, high=3, low=3; assert abort in the 2nd cycle of the 3rd high phase → pulse_out=0 next cycle, busy=0, done=0, sent=2.
- Handshake:
  - start pulsed during a running burst → ignored, and the first burst completes unchanged.
  - start in the cycle after FIN → new burst begins; the gap shows 2 cycles of pulse_out=0.
- Reset and cross-check:
  - rst=0 asynchronously mid-HIGH → pulse_out, busy and sent are 0 before the next clk edge; after release, idle until start.
  - Feed pulse_out into the high counter for count=1000 → the counter reads 1000.

Source files
------------

// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse-train generator and its counter-side checker.
package pulse_train_gen_pkg;

    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned DUR_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_FIN  = 2'd3
    } pt_state_e;

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; expired marks the last phase cycle.
module pulse_phase_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    // Saturating decrement; a load overrides the count.
    always_comb begin
        cnt_nxt = cnt;
        if (load) begin
            cnt_nxt = value;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - W'(1);
        end
    end

    // expired is registered alongside the count so it is valid in the cycle the count is 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            expired <= 1'b1;
        end else begin
            cnt     <= cnt_nxt;
            expired <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/pulse_train_gen.sv
// Burst generator: emits pulse_count high pulses of programmable high/low width with a start/busy/done handshake.
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DUR_W = DUR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pulse_count,
    input  logic [DUR_W-1:0] high_cycles,
    input  logic [DUR_W-1:0] low_cycles,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
);

    pt_state_e        state;
    logic [CNT_W-1:0] cfg_count;
    logic [DUR_W-1:0] cfg_high;
    logic [DUR_W-1:0] cfg_low;
    logic [CNT_W-1:0] sent_inc;
    logic             accept;
    logic             phase_end;
    logic             timer_load;
    logic [DUR_W-1:0] timer_value;

    // Zero durations behave as one cycle; the timer counts target-1 down to 0.
    function automatic logic [DUR_W-1:0] phase_load(input logic [DUR_W-1:0] d);
        return (d == '0) ? '0 : d - DUR_W'(1);
    endfunction

    assign sent_inc = sent + CNT_W'(1);
    assign accept   = start && !abort;

    // Timer load on every entry into HIGH or LOW.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = phase_load(cfg_high);
        case (state)
            ST_IDLE: begin
                if (accept && pulse_count != '0) begin
                    timer_load  = 1'b1;
                    timer_value = phase_load(high_cycles);
                end
            end
            ST_HIGH: begin
                if (!abort && phase_end && sent_inc != cfg_count) begin
                    timer_load  = 1'b1;
                    timer_value = phase_load(cfg_low);
                end
            end
            ST_LOW: begin
                if (!abort && phase_end) begin
                    timer_load  = 1'b1;
                    timer_value = phase_load(cfg_high);
                end
            end
            default: ;
        endcase
    end

    pulse_phase_timer #(
        .W (DUR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .value   (timer_value),
        .expired (phase_end)
    );

    // Burst FSM with registered outputs and sent counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cfg_count <= '0;
            cfg_high  <= '0;
            cfg_low   <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sent      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cfg_count <= pulse_count;
                        cfg_high  <= high_cycles;
                        cfg_low   <= low_cycles;
                        sent      <= '0;
                        if (pulse_count != '0) begin
                            state     <= ST_HIGH;
                            pulse_out <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        pulse_out <= 1'b0;
                        busy      <= 1'b0;
                    end else if (phase_end) begin
                        sent      <= sent_inc;
                        pulse_out <= 1'b0;
                        if (sent_inc == cfg_count) begin
                            state <= ST_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (phase_end) begin
                        state     <= ST_HIGH;
                        pulse_out <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed table-driven bench for pulse_train_gen plus hand-written abort/reset/long-burst sequences.
module tb_pulse_train_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] pulse_count;
    logic [15:0] high_cycles;
    logic [15:0] low_cycles;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic [31:0] sent;

    int errors;
    int checks;

    typedef struct {
        logic        st;
        logic [31:0] cnt;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        p;
        logic        b;
        logic        d;
        logic [31:0] s;
    } vec_t;

    vec_t vecs[$];

    pulse_train_gen u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pulse_count (pulse_count),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .sent        (sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic p, input logic b,
                              input logic d, input logic [31:0] s);
        check({tag, " pulse_out"}, 32'(pulse_out), 32'(p));
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " done"}, 32'(done), 32'(d));
        check({tag, " sent"}, sent, s);
    endtask

    function automatic vec_t mk(input logic st, input logic [31:0] cnt, input logic [15:0] hi,
                                input logic [15:0] lo, input logic p, input logic b,
                                input logic d, input logic [31:0] s);
        vec_t v;
        v.st = st; v.cnt = cnt; v.hi = hi; v.lo = lo;
        v.p = p; v.b = b; v.d = d; v.s = s;
        return v;
    endfunction

    initial begin
        int rises;
        int highs;
        logic prev;
        bit timed_out;

        errors = 0;
        checks = 0;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pulse_count = '0;
        high_cycles = '0;
        low_cycles = '0;

        // basic burst count=3 high=2 low=1; row 3 carries an ignored start with new config
        vecs.push_back(mk(1, 3, 2, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 7, 5, 5, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3));
        // start during FIN is ignored
        vecs.push_back(mk(1, 2, 1, 1, 0, 0, 0, 3));
        // zero-count burst
        vecs.push_back(mk(1, 0, 4, 4, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // zero durations: toggle every cycle, 4 highs
        vecs.push_back(mk(1, 4, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4));
        // back-to-back start in the IDLE cycle after FIN
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));

        step();
        step();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        step();
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            start       = vecs[i].st;
            pulse_count = vecs[i].cnt;
            high_cycles = vecs[i].hi;
            low_cycles  = vecs[i].lo;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].p, vecs[i].b, vecs[i].d, vecs[i].s);
        end
        start = 1'b0;

        // abort in the 2nd cycle of the 3rd high phase
        start = 1'b1; pulse_count = 10; high_cycles = 3; low_cycles = 3;
        step();
        start = 1'b0;
        for (int i = 1; i <= 13; i++) step();
        check_outs("pre_abort", 1'b1, 1'b1, 1'b0, 32'd2);
        abort = 1'b1;
        step();
        check_outs("abort", 1'b0, 1'b0, 1'b0, 32'd2);
        abort = 1'b0;
        step();
        check_outs("abort_idle", 1'b0, 1'b0, 1'b0, 32'd2);

        // abort beats start in IDLE
        abort = 1'b1; start = 1'b1; pulse_count = 5; high_cycles = 1; low_cycles = 1;
        step();
        abort = 1'b0; start = 1'b0;
        check_outs("abort_start", 1'b0, 1'b0, 1'b0, 32'd2);
        step();
        check_outs("abort_start2", 1'b0, 1'b0, 1'b0, 32'd2);

        // asynchronous reset mid-HIGH
        start = 1'b1; pulse_count = 5; high_cycles = 4; low_cycles = 1;
        step();
        start = 1'b0;
        step();
        check_outs("pre_reset", 1'b1, 1'b1, 1'b0, 32'd0);
        #2 rst = 1'b0;
        #1;
        check_outs("async_reset", 1'b0, 1'b0, 1'b0, 32'd0);
        step();
        rst = 1'b1;
        step();
        step();
        check_outs("reset_idle", 1'b0, 1'b0, 1'b0, 32'd0);

        // long burst: count rising edges of pulse_out
        start = 1'b1; pulse_count = 1000; high_cycles = 2; low_cycles = 3;
        rises = 0;
        highs = 0;
        prev = 1'b0;
        timed_out = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (pulse_out && !prev) rises++;
            if (pulse_out) highs++;
            prev = pulse_out;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            step();
        end
        check("long_timeout", 32'(timed_out), 32'd0);
        check("long_rises", 32'(rises), 32'd1000);
        check("long_high_cycles", 32'(highs), 32'd2000);
        check("long_sent", sent, 32'd1000);
        check("long_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
